// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel FSM encoding and
// counter sizing helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  // Bits needed to hold values 0..terminal (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned terminal);
    if (terminal == 0) begin
      return 1;
    end
    return $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debouncer, edge pulses and the
// press / long-press / auto-repeat state machine.
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 5,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_press,
  output logic hold,
  output logic rpt
);

  localparam int unsigned DbW   = cnt_width(DB_CYCLES - 1);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES - 1);
  localparam int unsigned RptW  = cnt_width(REPEAT_CYCLES - 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RptW-1:0]  RptLast  = RptW'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [DbW-1:0]         db_cnt;
  logic                   flip;
  logic                   rise;
  logic                   fall;
  btn_state_e             state;
  logic [HoldW-1:0]       hold_cnt;
  logic [RptW-1:0]        rpt_cnt;

  assign s = sync[SYNC_STAGES-1];

  // Debounced level changes on the edge where the disagreement count is terminal.
  assign flip = (s != level) && (db_cnt == DbLast);
  assign rise = flip & ~level;
  assign fall = flip & level;

  assign hold = (state == HELD);

  // Synchroniser chain for the raw asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pb};
    end
  end

  // Debounce counter, level register and registered edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      press <= rise;
      rel   <= fall;
      if (s == level) begin
        db_cnt <= '0;
      end else if (flip) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Press / hold / repeat FSM; release always wins over hold or repeat events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      rpt_cnt    <= '0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
    end else begin
      long_press <= 1'b0;
      rpt        <= 1'b0;
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          rpt_cnt  <= '0;
          if (rise) begin
            state <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == HoldLast) begin
            state      <= HELD;
            long_press <= 1'b1;
            hold_cnt   <= '0;
            rpt_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end else if (!repeat_en) begin
            rpt_cnt <= '0;
          end else if (rpt_cnt == RptLast) begin
            rpt     <= 1'b1;
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
          rpt_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: N_CH independent btn_chan instances.
// The release pulse output is named rel because release is a reserved word.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_CH          = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 5,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] hold,
  output logic [N_CH-1:0] rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .pb        (pb[i]),
      .repeat_en (repeat_en[i]),
      .level     (level[i]),
      .press     (press[i]),
      .rel       (rel[i]),
      .long_press(long_press[i]),
      .hold      (hold[i]),
      .rpt       (rpt[i])
    );
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_CH, default 3: number of independent button channels, range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, range 2..4.
REQ-003 Parameter DB_CYCLES, default 5: consecutive agreeing samples required to change debounced state, range 1..65535.
REQ-004 Parameter HOLD_CYCLES, default 1000: cycles of stable press before long-press, range 1..2^24-1.
REQ-005 Parameter REPEAT_CYCLES, default 250: auto-repeat period after long-press, range 1..2^24-1.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 pb  input  N_CH  raw asynchronous button inputs, 1 = pressed.
REQ-009 repeat_en  input  N_CH  per-channel auto-repeat enable, sampled every cycle.
REQ-010 level  output  N_CH  debounced button state.
REQ-011 press  output  N_CH  one-cycle pulse on debounced rising edge.
REQ-012 release  output  N_CH  one-cycle pulse on debounced falling edge.
REQ-013 long_press  output  N_CH  one-cycle pulse when hold threshold is reached.
REQ-014 hold  output  N_CH  high from long_press until release.
REQ-015 rpt  output  N_CH  one-cycle auto-repeat pulse.

Function
REQ-016 Each pb bit shall pass through SYNC_STAGES flops; only the last stage (s) feeds logic.
REQ-017 Per channel, when s != level, db counter shall increment; when s == level, it shall clear to 0.
REQ-018 When s != level and db counter == DB_CYCLES-1, level shall toggle and the counter shall clear on the same edge.
REQ-019 A clean pb transition shall change level on the (SYNC_STAGES+DB_CYCLES)th rising edge sampling the new value; any glitch shorter than DB_CYCLES synchronised samples shall not change level.
REQ-020 press/release shall be registered and high exactly in the cycle in which level has just changed (same edge as level update).
REQ-021 Per-channel FSM states: IDLE (level=0), PRESSED, HELD; IDLE->PRESSED on press, PRESSED->HELD on hold counter == HOLD_CYCLES-1, PRESSED/HELD->IDLE on release.
REQ-022 Hold counter shall clear on entry to PRESSED and count each cycle in PRESSED; long_press shall pulse on the PRESSED->HELD edge.
REQ-023 hold shall equal (state == HELD).
REQ-024 In HELD, repeat counter shall clear on entry and count each cycle; when it reaches REPEAT_CYCLES-1 and repeat_en=1, rpt shall pulse and counter shall wrap to 0.
REQ-025 With repeat_en=0 in HELD, repeat counter shall be held at 0 and rpt shall stay 0; reasserting repeat_en starts a full REPEAT_CYCLES period.
REQ-026 First rpt shall occur REPEAT_CYCLES cycles after long_press, never coincident with it.
REQ-027 Release in HELD on the same edge as a due rpt shall suppress rpt; release has priority.
REQ-028 Counters shall saturate-free never exceed terminal value; widths shall be $clog2(terminal+1).
REQ-029 Channels shall be fully independent; simultaneous events on any channels shall all be reported in the same cycle.

Reset
REQ-030 While rst=1 all synchroniser flops, counters, level, and FSM (IDLE) shall be 0/IDLE and all outputs 0, asynchronously.
REQ-031 A button held through reset deassertion shall produce press after SYNC_STAGES+DB_CYCLES edges; no release shall be emitted for a press interrupted by reset.

Structure
REQ-032 Package btn_pkg shall hold the state encoding (IDLE, PRESSED, HELD) and a counter-width function.
REQ-033 Sub-module btn_chan shall implement one channel (REQ-016..REQ-027); top replicates N_CH instances via generate.

Verification (N_CH=3, SYNC_STAGES=2, DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-034 pb[0] 0->1 held -> level[0] and press[0] rise at 6th edge sampling 1; press[0] high 1 cycle.
REQ-035 pb[1] high 3 cycles then low -> level[1], press[1], release[1] stay 0.
REQ-036 pb[2] held 30 cycles, repeat_en[2]=1 -> long_press 10 cycles after press, rpt every 3 cycles thereafter, hold high until release.
REQ-037 Same as 036 with repeat_en[2]=0 -> long_press and hold occur, rpt never pulses.
REQ-038 pb all three rise same cycle -> press=3'b111 in one cycle; rst pulse mid-HELD -> all outputs 0 immediately, press re-emitted 6 edges after rst release.
